lc3_io_responder: RTL
=====================

Name: lc3_io_responder

Overview:
- Memory-mapped I/O responder on the LC-3 memory bus (mar/mdr/memwe/memOut); it answers processor accesses to the device-register page.
- Implements the keyboard (KBSR/KBDR), display (DSR/DDR) and machine-control (MCR) registers.
- Bridges them to valid/ready character streams for the testbench or a UART.
- The top level muxes io_rdata onto memOut when io_sel is high; RAM serves all other addresses.

Parameters:
- KBSR_ADDR, 16'hFE00, keyboard status address
- KBDR_ADDR, 16'hFE02, keyboard data address
- DSR_ADDR, 16'hFE04, display status address
- DDR_ADDR, 16'hFE06, display data address
- MCR_ADDR, 16'hFFFE, machine control address
- CHAR_W, 8, character width on both streams

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high
- mar  in  16  bus address from processor
- mdr  in  16  bus write data
- memwe  in  1  write enable; a write occurs on the edge where memwe=1 and io_sel=1
- io_sel  out  1  combinational: mar matches one of the five device addresses
- io_rdata  out  16  registered read data
- kb_valid  in  1  keyboard character offered
- kb_data  in  CHAR_W  keyboard character
- kb_ready  out  1  responder can accept a character
- disp_valid  out  1  display character pending
- disp_data  out  CHAR_W  display character
- disp_ready  in  1  display sink accepts
- kb_irq  out  1  KBSR[15] & KBSR[14]
- mcr_run  out  1  MCR[15]; processor halts when 0

Behaviour:
- Reset values:
  - KBSR=0, KBDR=0, DSR=16'h8000, DDR=0, MCR=16'h8000.
  - io_rdata=0, kb_ready=1, disp_valid=0, disp_data=0, kb_irq=0, mcr_run=1.
- Read latency:
  - io_rdata is updated on every edge with the register selected by mar; this gives 1-cycle latency, matching RAM.
  - If mar is not a device address, io_rdata=0.
- Register read values:
  - KBSR = {rdy, ie, 14'b0}
  - KBDR = {8'b0, char}
  - DSR = {rdy, 14'b0, ovr}
  - DDR = {8'b0, last char}
- Keyboard channel:
  - kb_ready = ~KBSR[15] (registered state, not combinational from kb_valid).
  - Capture occurs when kb_valid & kb_ready: KBDR<=kb_data and KBSR[15]<=1.
  - Read-clear:
    - Defined as a read (memwe=0) with mar==KBDR_ADDR on a cycle where the previous cycle was not a KBDR read; this uses a 1-bit kbdr_rd_q edge detector.
    - Read-clear sets KBSR[15]<=0.
    - Holding mar on KBDR for many cycles clears only once. A char arriving during the hold is retained.
  - Capture and read-clear on the same edge cannot occur because kb_ready=0 while full.
  - A write to KBSR updates only bit14 (ie). Writes to KBDR are ignored.
- Display channel:
  - A write to DDR with DSR[15]=1: DDR<=mdr[7:0], disp_data<=mdr[7:0], disp_valid<=1, DSR[15]<=0.
  - A write to DDR with DSR[15]=0: data is dropped, DDR/disp_data unchanged, and DSR[0] (ovr, sticky) <=1.
  - Handshake: disp_valid & disp_ready causes disp_valid<=0 and DSR[15]<=1 on the same edge.
    - disp_data must be held stable while disp_valid=1.
  - A write to DDR on the same edge as the handshake completion counts as DSR[15]=0, i.e. overrun (status is read pre-edge).
  - A write to DSR clears ovr. Other DSR bits are read-only.
- MCR:
  - A write loads all 16 bits; mcr_run=MCR[15] is registered.
  - Writing 0 halts; only reset restores it.
- Reset mid-operation: a pending display char is discarded (disp_valid drops the next edge), a held keyboard char is lost, and kbdr_rd_q is cleared.

Decomposition:
- Package lc3_io_pkg holds:
  - address constants
  - bit-index constants: RDY=15, IE=14, OVR=0
  - typedef io_reg_e {IO_NONE, IO_KBSR, IO_KBDR, IO_DSR, IO_DDR, IO_MCR}
  - function decode_io(addr) -> io_reg_e
- One sub-module, lc3_io_chan_reg: a one-entry valid/ready holding register with set/clear/full.
  - Instantiated twice: keyboard (stream-in, bus-out) and display (bus-in, stream-out).

Test Plan:
1. Reset, then read MCR and DSR (mar=FFFE, then FE04) -> io_rdata=16'h8000 each one cycle later; kb_ready=1; disp_valid=0; io_sel=1. mar=3000 -> io_sel=0, io_rdata=0.
2. kb_valid=1, kb_data=8'h41 for one cycle -> kb_ready=0 next cycle. Read KBSR gives 16'h8000; read KBDR gives 16'h0041. KBSR then reads 0 and kb_ready=1. Write KBSR=16'h4000 then inject 8'h42 -> kb_irq=1.
3. Hold mar=FE02 for 6 cycles and inject 8'h43 in cycle 3 after the first clear -> KBSR[15] remains 1 and KBDR=0043 (not lost).
4. Write DDR=16'h1234 with disp_ready=0 -> disp_valid=1, disp_data=8'h34, DSR=0000. Write DDR=16'h0055 -> DSR=0001 and disp_data still 34. Assert disp_ready for one cycle -> DSR=8001, disp_valid=0. Write DSR -> DSR=8000.
5. Same-edge case: disp_valid=1, disp_ready=1 and write DDR=16'h0066 on the same edge -> the char is dropped, ovr=1, DSR=8001.
6. Write MCR=16'h0000 -> mcr_run=0 next cycle. Assert reset for one cycle while disp_valid=1 and KBSR[15]=1 -> all outputs return to reset values on the following edge.

Source files
------------

// File: rtl/lc3_io_pkg.sv
// Shared constants and address decode for the LC-3 device-register page.
package lc3_io_pkg;

  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;
  localparam logic [15:0] MCR_ADDR  = 16'hFFFE;

  localparam int CHAR_W = 8;

  localparam int RDY = 15;
  localparam int IE  = 14;
  localparam int OVR = 0;

  typedef enum logic [2:0] {
    IO_NONE,
    IO_KBSR,
    IO_KBDR,
    IO_DSR,
    IO_DDR,
    IO_MCR
  } io_reg_e;

  function automatic io_reg_e decode_io(input logic [15:0] addr);
    io_reg_e r;
    case (addr)
      KBSR_ADDR: r = IO_KBSR;
      KBDR_ADDR: r = IO_KBDR;
      DSR_ADDR:  r = IO_DSR;
      DDR_ADDR:  r = IO_DDR;
      MCR_ADDR:  r = IO_MCR;
      default:   r = IO_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lc3_io_chan_reg.sv
// One-entry holding register: loads on set when empty, empties on clr when full.
module lc3_io_chan_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         set_i,
  input  logic         clr_i,
  input  logic [W-1:0] data_i,
  output logic         full_o,
  output logic [W-1:0] data_o
);

  logic         full_q;
  logic [W-1:0] data_q;

  // set is ignored while full, so a full entry's data never changes underneath the reader
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (full_q) begin
      if (clr_i) full_q <= 1'b0;
    end else if (set_i) begin
      full_q <= 1'b1;
      data_q <= data_i;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/lc3_io_responder.sv
// LC-3 memory-mapped keyboard, display and machine-control registers,
// bridged to valid/ready character streams.
module lc3_io_responder
  import lc3_io_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       mar,
  input  logic [15:0]       mdr,
  input  logic              memwe,
  output logic              io_sel,
  output logic [15:0]       io_rdata,
  input  logic              kb_valid,
  input  logic [CHAR_W-1:0] kb_data,
  output logic              kb_ready,
  output logic              disp_valid,
  output logic [CHAR_W-1:0] disp_data,
  input  logic              disp_ready,
  output logic              kb_irq,
  output logic              mcr_run
);

  localparam int PAD = 16 - CHAR_W;

  io_reg_e           sel;
  logic              wr;
  logic              kbdr_rd, kbdr_rd_q, kb_clr;
  logic              kb_full;
  logic [CHAR_W-1:0] kb_char;
  logic              ie_q, ovr_q;
  logic [15:0]       mcr_q;
  logic [15:0]       io_rdata_q, io_rdata_d;
  logic [15:0]       kbsr_v, dsr_v;

  assign sel     = decode_io(mar);
  assign io_sel  = (sel != IO_NONE);
  assign wr      = memwe & io_sel;
  assign kbdr_rd = ~memwe & (sel == IO_KBDR);
  // clear only on the first cycle of a KBDR read so a long hold does not eat a new char
  assign kb_clr  = kbdr_rd & ~kbdr_rd_q;

  lc3_io_chan_reg #(.W(CHAR_W)) u_kb (
    .clk    (clk),
    .reset  (reset),
    .set_i  (kb_valid),
    .clr_i  (kb_clr),
    .data_i (kb_data),
    .full_o (kb_full),
    .data_o (kb_char)
  );

  lc3_io_chan_reg #(.W(CHAR_W)) u_disp (
    .clk    (clk),
    .reset  (reset),
    .set_i  (wr && sel == IO_DDR),
    .clr_i  (disp_ready),
    .data_i (mdr[CHAR_W-1:0]),
    .full_o (disp_valid),
    .data_o (disp_data)
  );

  assign kbsr_v = {kb_full, ie_q, 14'b0};
  assign dsr_v  = {~disp_valid, 14'b0, ovr_q};

  always_comb begin
    io_rdata_d = '0;
    case (sel)
      IO_KBSR: io_rdata_d = kbsr_v;
      IO_KBDR: io_rdata_d = {{PAD{1'b0}}, kb_char};
      IO_DSR:  io_rdata_d = dsr_v;
      IO_DDR:  io_rdata_d = {{PAD{1'b0}}, disp_data};
      IO_MCR:  io_rdata_d = mcr_q;
      default: io_rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ie_q       <= 1'b0;
      ovr_q      <= 1'b0;
      mcr_q      <= 16'h8000;
      io_rdata_q <= '0;
      kbdr_rd_q  <= 1'b0;
    end else begin
      io_rdata_q <= io_rdata_d;
      kbdr_rd_q  <= kbdr_rd;
      if (wr && sel == IO_KBSR) ie_q <= mdr[IE];
      if (wr && sel == IO_DSR)  ovr_q <= 1'b0;
      // status is sampled pre-edge, so a write racing the handshake still overruns
      if (wr && sel == IO_DDR && disp_valid) ovr_q <= 1'b1;
      if (wr && sel == IO_MCR) mcr_q <= mdr;
    end
  end

  assign io_rdata = io_rdata_q;
  assign kb_ready = ~kb_full;
  assign kb_irq   = kb_full & ie_q;
  assign mcr_run  = mcr_q[RDY];

endmodule
